abacus_counter_reader: RTL and testbench

ABACUS_COUNTER_READER -- requirements
Module: abacus_counter_reader

---
 rtl/abacus_pkg.sv | 27 ++
 rtl/abacus_counter_reader_if.sv | 34 +++
 rtl/abacus_timeout_counter.sv | 26 ++
 rtl/abacus_counter_reader.sv | 117 +++++++++++
 tb/tb_abacus_counter_reader.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/abacus_pkg.sv
// Shared types and constants for the ABACUS counter reader.
// Holds the FSM state enum, counter-map offsets and an address helper.
package abacus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        OUT,
        FINISH,
        ABORT
    } state_t;

    // ABACUS counter-map offsets relative to the block base
    localparam logic [11:0] OFS_ENABLE0     = 12'h004;
    localparam logic [11:0] OFS_ENABLE1     = 12'h008;
    localparam logic [11:0] OFS_INSN_BLOCK  = 12'h100;
    localparam logic [11:0] OFS_CACHE_BLOCK = 12'h200;

    // Byte address of word idx; wraps modulo 2^32
    function automatic logic [31:0] word_addr(
        input logic [31:0] base,
        input logic [31:0] idx
    );
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/abacus_counter_reader_if.sv
// Wishbone classic master bus plus read-word output stream.
// master: reader side (drives wb_* controls and m_t* data); slave: bus/sink side.
interface abacus_counter_reader_if #(
    parameter int MAX_WORDS = 32
);
    localparam int IW = $clog2(MAX_WORDS);

    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [31:0]   wb_adr;
    logic [31:0]   wb_dat_o;
    logic [31:0]   wb_dat_i;
    logic          wb_ack;
    logic [31:0]   m_tdata;
    logic [IW-1:0] m_tindex;
    logic          m_tvalid;
    logic          m_tready;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
        input  wb_dat_i, wb_ack,
        output m_tdata, m_tindex, m_tvalid,
        input  m_tready
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
        output wb_dat_i, wb_ack,
        input  m_tdata, m_tindex, m_tvalid,
        output m_tready
    );

endinterface

// File: rtl/abacus_timeout_counter.sv
// Counts enabled cycles; expired flags the cycle the count reaches TIMEOUT_CYCLES.
// Ports: clk, rst (sync active-low), clear, enable in; expired out.
module abacus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + W'(1);
    end

    // This enabled cycle is the TIMEOUT_CYCLES-th one
    assign expired = enable && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/abacus_counter_reader.sv
// Burst reader: fetches word_count words over Wishbone and streams them out.
// Ports: clk, rst, start, base_addr_sel, base_addr, word_count in; busy, done, error out; bus (master).
module abacus_counter_reader
    import abacus_pkg::*;
#(
    parameter logic [31:0] DEFAULT_BASE_ADDR = 32'hf0030100,
    parameter int          MAX_WORDS         = 32,
    parameter int          TIMEOUT_CYCLES    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         base_addr_sel,
    input  logic [31:0]                  base_addr,
    input  logic [$clog2(MAX_WORDS):0]   word_count,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    abacus_counter_reader_if.master      bus
);
    localparam int IW = $clog2(MAX_WORDS);
    localparam int CW = IW + 1;

    state_t        state, state_n;
    logic [31:0]   addr;
    logic [CW-1:0] count;
    logic [IW-1:0] idx;
    logic [31:0]   tdata;
    logic          expired;
    logic          last;
    logic [31:0]   sel_addr;
    logic [CW-1:0] wc_clamp;

    assign sel_addr = base_addr_sel ? base_addr : DEFAULT_BASE_ADDR;
    assign wc_clamp = (word_count > CW'(MAX_WORDS)) ? CW'(MAX_WORDS)
                                                    : word_count;
    assign last     = ({1'b0, idx} + CW'(1)) == count;

    // Counter is held clear outside REQ, so each REQ entry starts from zero
    abacus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != REQ),
        .enable ((state == REQ) && !bus.wb_ack),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            addr  <= '0;
            count <= '0;
            idx   <= '0;
            tdata <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: if (start && word_count != '0) begin
                    addr  <= {sel_addr[31:2], 2'b00};
                    count <= wc_clamp;
                    idx   <= '0;
                end
                REQ: if (bus.wb_ack)
                    tdata <= bus.wb_dat_i;
                OUT: if (bus.m_tready && !last)
                    idx <= idx + IW'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b1;
        done    = 1'b0;
        error   = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_n = (word_count == '0) ? FINISH : REQ;
            end
            // Ack wins over a coincident timeout
            REQ: begin
                if (bus.wb_ack)
                    state_n = OUT;
                else if (expired)
                    state_n = ABORT;
            end
            OUT: begin
                if (bus.m_tready)
                    state_n = last ? FINISH : REQ;
            end
            FINISH: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            ABORT: begin
                error   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.wb_cyc   = (state == REQ);
    assign bus.wb_stb   = (state == REQ);
    assign bus.wb_we    = 1'b0;
    assign bus.wb_dat_o = '0;
    assign bus.wb_adr   = (state == REQ) ? word_addr(addr, 32'(idx)) : '0;
    assign bus.m_tvalid = (state == OUT);
    assign bus.m_tdata  = tdata;
    assign bus.m_tindex = idx;

endmodule

// File: tb/tb_abacus_counter_reader.sv
// Directed bench for abacus_counter_reader with a Wishbone slave model.
// Slave returns adr ^ KEY one cycle after strobe; monitor logs bus and stream.
module tb_abacus_counter_reader;

    localparam int          MW   = 8;
    localparam int          TO   = 4;
    localparam int          CW   = 4;
    localparam int          IW   = 3;
    localparam logic [31:0] KEY  = 32'ha5a50000;
    localparam logic [31:0] DEF  = 32'hf0030100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          base_addr_sel = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic          busy, done, error;

    abacus_counter_reader_if #(.MAX_WORDS(MW)) bus();

    abacus_counter_reader #(
        .DEFAULT_BASE_ADDR(DEF),
        .MAX_WORDS        (MW),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr_sel(base_addr_sel),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave / sink model
    bit no_ack = 1'b0;
    bit bp_en  = 1'b0;
    int wcnt   = 0;
    int hold   = 0;

    initial begin
        bus.wb_ack   = 1'b0;
        bus.wb_dat_i = '0;
        bus.m_tready = 1'b1;
    end

    always begin
        @(posedge clk);
        #1;
        if (bus.wb_stb && !no_ack) begin
            if (wcnt >= 1) begin
                bus.wb_ack   = 1'b1;
                bus.wb_dat_i = bus.wb_adr ^ KEY;
            end else begin
                bus.wb_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus.wb_ack = 1'b0;
            wcnt = 0;
        end
        if (bp_en && bus.m_tvalid && bus.m_tindex == 1 && hold < 10) begin
            bus.m_tready = 1'b0;
            hold++;
        end else begin
            bus.m_tready = 1'b1;
        end
    end

    // Monitor
    logic [31:0]   adr_q[$];
    logic [31:0]   dat_q[$];
    int            idx_q[$];
    int            n_done, n_err, n_cyc, n_stb, n_tv, n_ovl, n_lat, n_unst;
    bit            prev_ack, prev_tv, prev_hs;
    logic [31:0]   prev_dat;
    logic [IW-1:0] prev_idx;

    task automatic clear_mon();
        adr_q.delete();
        dat_q.delete();
        idx_q.delete();
        n_done = 0; n_err = 0; n_cyc = 0; n_stb = 0;
        n_tv = 0; n_ovl = 0; n_lat = 0; n_unst = 0;
        prev_ack = 0; prev_tv = 0; prev_hs = 0;
        prev_dat = '0; prev_idx = '0;
    endtask

    always @(negedge clk) begin
        if (bus.wb_stb && bus.wb_ack) adr_q.push_back(bus.wb_adr);
        if (bus.m_tvalid && bus.m_tready) begin
            dat_q.push_back(bus.m_tdata);
            idx_q.push_back(int'(bus.m_tindex));
        end
        if (prev_ack && !bus.m_tvalid) n_lat++;
        if (bus.m_tvalid && prev_tv && !prev_hs &&
            (bus.m_tdata !== prev_dat || bus.m_tindex !== prev_idx))
            n_unst++;
        if (done)       n_done++;
        if (error)      n_err++;
        if (bus.wb_cyc) n_cyc++;
        if (bus.wb_stb) n_stb++;
        if (bus.m_tvalid) n_tv++;
        if (bus.wb_cyc && bus.m_tvalid) n_ovl++;
        prev_ack = bus.wb_stb && bus.wb_ack;
        prev_tv  = bus.m_tvalid;
        prev_hs  = bus.m_tvalid && bus.m_tready;
        prev_dat = bus.m_tdata;
        prev_idx = bus.m_tindex;
    end

    task automatic do_burst(input logic sel, input logic [31:0] base,
                            input logic [CW-1:0] wc,
                            output int lat_stb, output int lat_done);
        @(posedge clk);
        clear_mon();
        @(negedge clk);
        base_addr_sel = sel;
        base_addr     = base;
        word_count    = wc;
        start         = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        lat_stb  = -1;
        lat_done = -1;
        for (int i = 0; i < 300; i++) begin
            if (bus.wb_stb && lat_stb < 0) lat_stb = i;
            if (done || error) begin
                lat_done = i;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_words(input string tag, input logic [31:0] base,
                             input int n);
        logic [31:0] a;
        chk({tag, " n_adr"}, adr_q.size(), n);
        chk({tag, " n_dat"}, dat_q.size(), n);
        for (int i = 0; i < n && i < adr_q.size() && i < dat_q.size(); i++) begin
            a = base + 32'(4 * i);
            chk($sformatf("%s adr%0d", tag, i), adr_q[i], a);
            chk($sformatf("%s dat%0d", tag, i), dat_q[i], a ^ KEY);
            chk($sformatf("%s idx%0d", tag, i), idx_q[i], i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1, "watchdog");
    end

    int  ls, ld;
    bit  found;

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst wb_cyc",   bus.wb_cyc,   0);
        chk("rst wb_stb",   bus.wb_stb,   0);
        chk("rst wb_we",    bus.wb_we,    0);
        chk("rst wb_adr",   bus.wb_adr,   0);
        chk("rst wb_dat_o", bus.wb_dat_o, 0);
        chk("rst m_tvalid", bus.m_tvalid, 0);
        chk("rst m_tdata",  bus.m_tdata,  0);
        chk("rst m_tindex", bus.m_tindex, 0);
        chk("rst busy",     busy,  0);
        chk("rst done",     done,  0);
        chk("rst error",    error, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Three words from the default base
        do_burst(1'b0, 32'h0, 4'd3, ls, ld);
        chk("b3 ended", ld >= 0, 1);
        chk("b3 lat stb", ls, 0);
        chk_words("b3", 32'hf0030100, 3);
        chk("b3 done", n_done, 1);
        chk("b3 err",  n_err, 0);
        chk("b3 lat ack-tvalid", n_lat, 0);
        chk("b3 tvalid cycles", n_tv, 3);
        chk("b3 overlap", n_ovl, 0);

        // Zero words: no bus activity
        do_burst(1'b0, 32'h0, 4'd0, ls, ld);
        chk("b0 done lat", ld, 0);
        chk("b0 cyc", n_cyc, 0);
        chk("b0 done", n_done, 1);
        chk("b0 tvalid", n_tv, 0);

        // Timeout abort
        no_ack = 1'b1;
        do_burst(1'b0, 32'h0, 4'd2, ls, ld);
        no_ack = 1'b0;
        chk("to ended", ld >= 0, 1);
        chk("to stb cycles", n_stb, 4);
        chk("to err", n_err, 1);
        chk("to done", n_done, 0);
        chk("to tvalid", n_tv, 0);

        // Backpressure on word 1
        hold  = 0;
        bp_en = 1'b1;
        do_burst(1'b0, 32'h0, 4'd3, ls, ld);
        bp_en = 1'b0;
        chk("bp ended", ld >= 0, 1);
        chk("bp held", hold, 10);
        chk("bp unstable", n_unst, 0);
        chk("bp overlap", n_ovl, 0);
        chk("bp tvalid cycles", n_tv, 13);
        chk_words("bp", 32'hf0030100, 3);
        chk("bp done", n_done, 1);

        // Reset during REQ of word 2 of 5
        @(posedge clk);
        clear_mon();
        @(negedge clk);
        base_addr_sel = 1'b0;
        word_count    = 4'd5;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.wb_stb && bus.m_tindex == 2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mr reach word2", found, 1);
        chk("mr busy before", busy, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mr wb_cyc", bus.wb_cyc, 0);
        chk("mr wb_stb", bus.wb_stb, 0);
        chk("mr busy",   busy,  0);
        chk("mr done",   done,  0);
        chk("mr error",  error, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mr n_done", n_done, 0);
        chk("mr n_err",  n_err, 0);
        do_burst(1'b0, 32'h0, 4'd2, ls, ld);
        chk("mr2 ended", ld >= 0, 1);
        chk_words("mr2", 32'hf0030100, 2);
        chk("mr2 done", n_done, 1);

        // Address wrap with run-time base
        do_burst(1'b1, 32'hfffffffc, 4'd2, ls, ld);
        chk("wr ended", ld >= 0, 1);
        chk("wr adr0", adr_q.size() > 0 ? adr_q[0] : 32'hx, 32'hfffffffc);
        chk("wr adr1", adr_q.size() > 1 ? adr_q[1] : 32'hx, 32'h00000000);
        chk("wr n", adr_q.size(), 2);

        // Low address bits ignored
        do_burst(1'b1, 32'h00001003, 4'd1, ls, ld);
        chk_words("lb", 32'h00001000, 1);

        // Count above MAX_WORDS clamps to 8
        do_burst(1'b0, 32'h0, 4'd12, ls, ld);
        chk("cl ended", ld >= 0, 1);
        chk_words("cl", 32'hf0030100, 8);
        chk("cl done", n_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
